// File: rtl/clock_mode_ctrl_if.sv
// Front-panel button levels and setter acks in; enables, pulses and load strobes out.
// The controller connects through the slave modport and the panel/setter side through the master modport.
interface clock_mode_ctrl_if;
    logic       time_button;
    logic       alarm_button;
    logic       mode_button;
    logic       inc_button;
    logic       time_ack;
    logic       alarm_ack;
    logic       clock_run;
    logic       set_time_en;
    logic       set_alarm_en;
    logic       mode_pulse;
    logic       inc_pulse;
    logic       load_time;
    logic       load_alarm;
    logic [1:0] digit_sel;
    logic       timeout_flag;

    modport master (
        output time_button, alarm_button, mode_button, inc_button, time_ack, alarm_ack,
        input  clock_run, set_time_en, set_alarm_en, mode_pulse, inc_pulse,
               load_time, load_alarm, digit_sel, timeout_flag
    );

    modport slave (
        input  time_button, alarm_button, mode_button, inc_button, time_ack, alarm_ack,
        output clock_run, set_time_en, set_alarm_en, mode_pulse, inc_pulse,
               load_time, load_alarm, digit_sel, timeout_flag
    );
endinterface

// File: rtl/clock_mode_ctrl.sv
// Clock mode controller: grants the front-panel buttons to RUN, set-time or set-alarm.
// Latency: 1 cycle, all outputs come straight from flops; no backpressure (one-cycle pulse interface).
module clock_mode_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    clock_mode_ctrl_if.slave bus
);
    localparam logic [2:0] S_RUN          = 3'd0;
    localparam logic [2:0] S_SET_TIME     = 3'd1;
    localparam logic [2:0] S_SET_ALARM    = 3'd2;
    localparam logic [2:0] S_COMMIT_TIME  = 3'd3;
    localparam logic [2:0] S_COMMIT_ALARM = 3'd4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       digit, digit_nx;
    logic             mode_p, mode_p_nx;
    logic             inc_p, inc_p_nx;
    logic             to_p, to_p_nx;
    logic [3:0]       btn, btn_q, rise;
    logic             own_rise, ack;
    logic [2:0]       commit_st;

    // Button order: time, alarm, mode, inc
    assign btn  = {bus.time_button, bus.alarm_button, bus.mode_button, bus.inc_button};
    assign rise = btn & ~btn_q;

    assign own_rise  = (state == S_SET_TIME) ? rise[3] : rise[2];
    assign ack       = (state == S_SET_TIME) ? bus.time_ack : bus.alarm_ack;
    assign commit_st = (state == S_SET_TIME) ? S_COMMIT_TIME : S_COMMIT_ALARM;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        digit_nx  = digit;
        mode_p_nx = 1'b0;
        inc_p_nx  = 1'b0;
        to_p_nx   = 1'b0;
        case (state)
            S_RUN: begin
                if (rise[3]) begin
                    state_nx = S_SET_TIME;
                    cnt_nx   = '0;
                    digit_nx = 2'd0;
                end else if (rise[2]) begin
                    state_nx = S_SET_ALARM;
                    cnt_nx   = '0;
                    digit_nx = 2'd0;
                end
            end
            S_SET_TIME, S_SET_ALARM: begin
                // Priority: cancel, mode (advance or commit), inc, inactivity timeout
                if (own_rise) begin
                    state_nx = S_RUN;
                    cnt_nx   = '0;
                end else if (rise[1]) begin
                    cnt_nx = '0;
                    if (ack) begin
                        state_nx = commit_st;
                    end else begin
                        mode_p_nx = 1'b1;
                        if (digit != 2'd3) digit_nx = digit + 2'd1;
                    end
                end else if (rise[0]) begin
                    cnt_nx   = '0;
                    inc_p_nx = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nx = S_RUN;
                    cnt_nx   = '0;
                    to_p_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: state_nx = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_RUN;
            cnt    <= '0;
            digit  <= 2'd0;
            btn_q  <= 4'd0;
            mode_p <= 1'b0;
            inc_p  <= 1'b0;
            to_p   <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            digit  <= digit_nx;
            btn_q  <= btn;
            mode_p <= mode_p_nx;
            inc_p  <= inc_p_nx;
            to_p   <= to_p_nx;
        end
    end

    // Load strobes are the one-cycle commit states, so the setter enable drops as the load rises
    assign bus.clock_run    = (state == S_RUN);
    assign bus.set_time_en  = (state == S_SET_TIME);
    assign bus.set_alarm_en = (state == S_SET_ALARM);
    assign bus.load_time    = (state == S_COMMIT_TIME);
    assign bus.load_alarm   = (state == S_COMMIT_ALARM);
    assign bus.mode_pulse   = mode_p;
    assign bus.inc_pulse    = inc_p;
    assign bus.timeout_flag = to_p;
    assign bus.digit_sel    = digit;
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: directed scenarios with literal expectations plus randomized button traffic
// compared every cycle against an event-level model (owner / committing / activity timestamp).
module tb_clock_mode_ctrl;
    localparam int TO = 20;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 0;

    clock_mode_ctrl_if bus ();

    clock_mode_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // setter: 0 nobody (RUN), 1 time, 2 alarm; commit marks the one load cycle
    typedef struct packed {
        logic [1:0]  setter;
        logic        commit;
        logic [1:0]  dig;
        logic [31:0] stamp;
        logic [31:0] cyc;
        logic        pt, pa, pm, pi;
        logic        mp, ip, to;
    } m_t;

    m_t m;

    function automatic m_t step(m_t s, logic t, logic a, logic mo, logic in, logic tack, logic aack);
        m_t n;
        logic et, ea, em, ei, own, ack;
        n = s;
        et = t & ~s.pt;
        ea = a & ~s.pa;
        em = mo & ~s.pm;
        ei = in & ~s.pi;
        n.pt = t; n.pa = a; n.pm = mo; n.pi = in;
        n.mp = 1'b0; n.ip = 1'b0; n.to = 1'b0;
        n.cyc = s.cyc + 1;
        if (s.commit) begin
            n.commit = 1'b0;
            n.setter = 2'd0;
        end else if (s.setter == 2'd0) begin
            if (et) begin
                n.setter = 2'd1; n.dig = 2'd0; n.stamp = s.cyc;
            end else if (ea) begin
                n.setter = 2'd2; n.dig = 2'd0; n.stamp = s.cyc;
            end
        end else begin
            own = (s.setter == 2'd1) ? et : ea;
            ack = (s.setter == 2'd1) ? tack : aack;
            if (own) begin
                n.setter = 2'd0;
            end else if (em) begin
                n.stamp = s.cyc;
                if (ack) n.commit = 1'b1;
                else begin
                    n.mp = 1'b1;
                    if (s.dig < 2'd3) n.dig = s.dig + 2'd1;
                end
            end else if (ei) begin
                n.stamp = s.cyc;
                n.ip = 1'b1;
            end else if (s.cyc - s.stamp == 32'(TO)) begin
                n.setter = 2'd0;
                n.to = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= '0;
        else m <= step(m, bus.time_button, bus.alarm_button, bus.mode_button, bus.inc_button,
                       bus.time_ack, bus.alarm_ack);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("clock_run",    int'(bus.clock_run),    int'(m.setter == 2'd0 && !m.commit));
            chk("set_time_en",  int'(bus.set_time_en),  int'(m.setter == 2'd1 && !m.commit));
            chk("set_alarm_en", int'(bus.set_alarm_en), int'(m.setter == 2'd2 && !m.commit));
            chk("load_time",    int'(bus.load_time),    int'(m.setter == 2'd1 && m.commit));
            chk("load_alarm",   int'(bus.load_alarm),   int'(m.setter == 2'd2 && m.commit));
            chk("mode_pulse",   int'(bus.mode_pulse),   int'(m.mp));
            chk("inc_pulse",    int'(bus.inc_pulse),    int'(m.ip));
            chk("timeout_flag", int'(bus.timeout_flag), int'(m.to));
            chk("digit_sel",    int'(bus.digit_sel),    int'(m.dig));
            chk("enables_onehot",
                int'(bus.clock_run) + int'(bus.set_time_en) + int'(bus.set_alarm_en) <= 1 ? 1 : 0, 1);
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.time_button = 0; bus.alarm_button = 0; bus.mode_button = 0;
        bus.inc_button = 0;  bus.time_ack = 0;     bus.alarm_ack = 0;
        tick(3);
        rst = 1'b1;
        chk_en = 1;

        // idle after reset
        tick(50);
        chk("idle_run", int'(bus.clock_run), 1);
        chk("idle_digit", int'(bus.digit_sel), 0);
        chk("idle_set_time_en", int'(bus.set_time_en), 0);

        // held time button: one entry, then cancel without load
        bus.time_button = 1; tick(1);
        chk("enter_set_time", int'(bus.set_time_en), 1);
        tick(4); bus.time_button = 0; tick(2);
        chk("held_single_entry", int'(bus.set_time_en), 1);
        bus.time_button = 1; tick(1);
        chk("cancel_run", int'(bus.clock_run), 1);
        chk("cancel_no_load", int'(bus.load_time), 0);
        bus.time_button = 0; tick(1);

        // digit advance then commit
        bus.time_button = 1; tick(1); bus.time_button = 0; tick(1);
        for (int k = 0; k < 3; k++) begin
            bus.mode_button = 1; tick(1);
            chk("adv_mode_pulse", int'(bus.mode_pulse), 1);
            chk("adv_digit", int'(bus.digit_sel), k + 1);
            bus.mode_button = 0; tick(1);
            chk("adv_pulse_one_cycle", int'(bus.mode_pulse), 0);
        end
        bus.time_ack = 1; bus.mode_button = 1; tick(1);
        chk("commit_no_mode_pulse", int'(bus.mode_pulse), 0);
        chk("commit_load_time", int'(bus.load_time), 1);
        chk("commit_en_dropped", int'(bus.set_time_en), 0);
        chk("commit_run_low", int'(bus.clock_run), 0);
        bus.mode_button = 0; tick(1);
        chk("after_commit_load", int'(bus.load_time), 0);
        chk("after_commit_run", int'(bus.clock_run), 1);
        bus.time_ack = 0;

        // simultaneous mode+inc, then held inc
        bus.alarm_button = 1; tick(1); bus.alarm_button = 0; tick(1);
        chk("enter_set_alarm", int'(bus.set_alarm_en), 1);
        bus.mode_button = 1; bus.inc_button = 1; tick(1);
        chk("mode_wins_mode", int'(bus.mode_pulse), 1);
        chk("mode_wins_inc", int'(bus.inc_pulse), 0);
        bus.mode_button = 0; tick(3);
        chk("held_inc_no_pulse", int'(bus.inc_pulse), 0);
        bus.inc_button = 0; tick(1);
        bus.inc_button = 1; tick(1);
        chk("repress_inc", int'(bus.inc_pulse), 1);
        tick(1);
        chk("repress_inc_once", int'(bus.inc_pulse), 0);
        bus.inc_button = 0;
        bus.alarm_button = 1; tick(1); bus.alarm_button = 0; tick(1);
        chk("alarm_cancel", int'(bus.clock_run), 1);

        // inactivity timeout
        bus.time_button = 1; tick(1); bus.time_button = 0;
        tick(TO - 1);
        chk("no_timeout_early", int'(bus.timeout_flag), 0);
        tick(1);
        chk("timeout_flag", int'(bus.timeout_flag), 1);
        chk("timeout_run", int'(bus.clock_run), 1);
        tick(1);
        chk("timeout_one_cycle", int'(bus.timeout_flag), 0);

        bus.time_button = 1; tick(1); bus.time_button = 0;
        tick(14);
        bus.inc_button = 1; tick(1); bus.inc_button = 0;
        tick(TO - 1);
        chk("restart_no_timeout", int'(bus.timeout_flag), 0);
        chk("restart_still_set", int'(bus.set_time_en), 1);
        tick(1);
        chk("restart_timeout", int'(bus.timeout_flag), 1);
        tick(1);

        // reset during commit-alarm
        bus.alarm_button = 1; tick(1); bus.alarm_button = 0; tick(1);
        bus.mode_button = 1; tick(1); bus.mode_button = 0; tick(1);
        bus.alarm_ack = 1; bus.mode_button = 1; tick(1);
        chk("commit_load_alarm", int'(bus.load_alarm), 1);
        chk("commit_alarm_digit", int'(bus.digit_sel), 1);
        rst = 1'b0; #1;
        chk("rst_load_alarm", int'(bus.load_alarm), 0);
        chk("rst_run", int'(bus.clock_run), 1);
        chk("rst_digit", int'(bus.digit_sel), 0);
        bus.mode_button = 0; bus.alarm_ack = 0;
        tick(1);
        rst = 1'b1;
        tick(2);

        // randomized traffic with quiet segments for timeouts
        for (int seg = 0; seg < 30; seg++) begin
            int rate;
            rate = $urandom_range(0, 3);
            for (int c = 0; c < 100; c++) begin
                if (rate != 0) begin
                    if ($urandom_range(0, 31) < rate) bus.time_button  = ~bus.time_button;
                    if ($urandom_range(0, 31) < rate) bus.alarm_button = ~bus.alarm_button;
                    if ($urandom_range(0, 7)  < rate) bus.mode_button  = ~bus.mode_button;
                    if ($urandom_range(0, 7)  < rate) bus.inc_button   = ~bus.inc_button;
                end
                bus.time_ack  = ($urandom_range(0, 3) == 0);
                bus.alarm_ack = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 999) == 0) begin
                    rst = 1'b0;
                    tick(1);
                    rst = 1'b1;
                end
                tick(1);
            end
            bus.time_button = 0; bus.alarm_button = 0;
            bus.mode_button = 0; bus.inc_button = 0;
        end
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
Top-level mode controller for the digital clock. It owns the four front-panel buttons and grants them to one of three users: the timekeeper (RUN), the time-setting unit, or the alarm-setting unit. It edge-detects the buttons and issues one-cycle mode/inc pulses plus enable levels to the active setter. It also issues a one-cycle load strobe when a setter completes, and aborts on a cancel press or an inactivity timeout.

Parameters:
TIMEOUT_CYCLES, 1000, idle cycles in a set state before automatic abort (must be >= 2)
CNT_W, 16, width of the inactivity counter (2^CNT_W > TIMEOUT_CYCLES)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
time_button  input  1  synchronized level; enter/cancel set-time
alarm_button  input  1  synchronized level; enter/cancel set-alarm
mode_button  input  1  synchronized level; advance digit / commit
inc_button  input  1  synchronized level; increment current digit
time_ack  input  1  set-time unit is on its last digit
alarm_ack  input  1  set-alarm unit is on its last digit
clock_run  output  1  timekeeper enable (high only in RUN)
set_time_en  output  1  enable to set-time unit
set_alarm_en  output  1  enable to set-alarm unit
mode_pulse  output  1  one-cycle mode advance to active setter
inc_pulse  output  1  one-cycle increment to active setter
load_time  output  1  one-cycle strobe: timekeeper loads setter digits
load_alarm  output  1  one-cycle strobe: alarm register loads setter digits
digit_sel  output  2  digit being edited (0=hours tens .. 3=minutes units), for display blink
timeout_flag  output  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async, rst=0): state=RUN, all button history regs=0, counter=0, digit_sel=0, all pulses/strobes=0, clock_run=1, set_*_en=0.
- Edge detect: per button, a register holds the last sample. The edge is the current level AND NOT the last sample. A held button yields exactly one edge.
- All outputs are registered. An event seen at edge N is visible in the cycle after edge N.
- States: RUN, SET_TIME, SET_ALARM, COMMIT_TIME, COMMIT_ALARM.
- Output decode: clock_run=(RUN); set_time_en=(SET_TIME); set_alarm_en=(SET_ALARM).
- RUN:
  - time edge -> SET_TIME.
  - alarm edge -> SET_ALARM.
  - If both arrive together, time wins.
  - Mode/inc edges are ignored; no pulses are issued.
  - On entry to either set state: digit_sel=0, counter=0.
- SET_TIME (SET_ALARM is identical, using alarm_button/alarm_ack/COMMIT_ALARM):
  - Own-button edge (time_button in SET_TIME) -> RUN, no load (cancel). The other setter's button is ignored.
  - Mode edge with time_ack=1 -> COMMIT_TIME. mode_pulse is not issued.
  - Mode edge with time_ack=0 -> mode_pulse=1 for one cycle; digit_sel saturates at 3.
  - Inc edge with no mode edge -> inc_pulse=1 for one cycle.
  - Mode and inc edges in the same cycle: mode wins, inc is dropped.
  - Cancel beats mode/inc in the same cycle.
- Inactivity counter (set states only):
  - Any mode or inc edge clears the counter; otherwise it increments.
  - When the counter equals TIMEOUT_CYCLES-1 with no edge that cycle -> RUN, timeout_flag=1 for one cycle, no load.
  - Counter is cleared on leaving the set state.
- COMMIT_TIME: load_time=1 for exactly one cycle, then unconditional -> RUN. All button edges in this state are ignored.
- set_time_en drops in the same cycle load_time rises. The setter's digit outputs hold their values, so the timekeeper samples valid digits with load_time.
- Never more than one of set_time_en, set_alarm_en, clock_run is high. clock_run is low during COMMIT_*.
- Reset mid-operation returns to RUN immediately with no load strobe.

Test Plan:
- Reset then idle 50 cycles -> clock_run=1, all other outputs 0, digit_sel=0.
- RUN, time_button high for 5 cycles -> set_time_en=1 from cycle after first high sample; single transition; releasing and re-pressing time_button -> back to RUN, load_time never asserted.
- SET_TIME, three mode presses with time_ack=0 -> three single-cycle mode_pulse, digit_sel 0->1->2->3. Fourth press with time_ack=1 -> no mode_pulse, load_time=1 for one cycle, then clock_run=1.
- SET_ALARM, mode and inc rise in the same cycle -> mode_pulse only, inc_pulse=0. Held inc after release/re-press -> exactly one inc_pulse per press.
- SET_TIME with TIMEOUT_CYCLES=20, no presses -> timeout_flag pulses after 20 cycles, returns to RUN. An inc press at cycle 15 delays the abort to 20 cycles after that press.
- Assert rst during COMMIT_ALARM -> load_alarm=0 immediately, state RUN, digit_sel=0.
